timer_unit_prescaler: RTL and testbench

Tick generator that sits directly upstream of the timer counter and drives its count-enable input. Selects between the system clock and an asynchronous low-frequency reference clock (synchronised and edge-detected internally) as the tick source. Optionally divides the selected source by a programmable 8-bit prescaler value. Emits one single-cycle `tick_o` pulse per counter increment.

---
 rtl/timer_unit_prescaler.sv | 65 ++++++
 tb/tb_timer_unit_prescaler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_unit_prescaler.sv
// timer_unit_prescaler: tick source for the timer counter.
// Picks clk or synchronised ref edges, optionally divides by value+1.
module timer_unit_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ref_clk_i,
  input  logic               enable_i,
  input  logic               reset_count_i,
  input  logic               ref_clk_en_i,
  input  logic               prescaler_en_i,
  input  logic [PRESC_W-1:0] prescaler_value_i,
  output logic               tick_o,
  output logic               ref_edge_o,
  output logic [PRESC_W-1:0] prescaler_count_o
);

  logic               s1;
  logic               s2;
  logic               s3;
  logic               ev;
  logic [PRESC_W-1:0] pcount;

  // three-flop chain; s3 is the delayed copy for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= ref_clk_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign ref_edge_o = s2 & ~s3;
  assign ev = ref_clk_en_i ? ref_edge_o : 1'b1;

  // prescaler count and tick, clear > enable > event > divide
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pcount <= '0;
      tick_o <= 1'b0;
    end else if (reset_count_i) begin
      pcount <= '0;
      tick_o <= 1'b0;
    end else if (!enable_i || !ev) begin
      tick_o <= 1'b0;
    end else if (!prescaler_en_i) begin
      pcount <= '0;
      tick_o <= 1'b1;
    end else if (pcount >= prescaler_value_i) begin
      pcount <= '0;
      tick_o <= 1'b1;
    end else begin
      pcount <= pcount + 1'b1;
      tick_o <= 1'b0;
    end
  end

  assign prescaler_count_o = pcount;

endmodule

// File: tb/tb_timer_unit_prescaler.sv
// tb_timer_unit_prescaler: directed checks of the tick generator.
// Inputs change 1ns after each rising edge; outputs are checked there.
module tb_timer_unit_prescaler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ref_clk = 1'b0;
  logic       enable = 1'b0;
  logic       reset_count = 1'b0;
  logic       ref_clk_en = 1'b0;
  logic       prescaler_en = 1'b0;
  logic [7:0] prescaler_value = 8'd0;
  logic       tick;
  logic       ref_edge;
  logic [7:0] prescaler_count;

  int checks = 0;
  int errors = 0;

  timer_unit_prescaler #(.PRESC_W(8)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .ref_clk_i         (ref_clk),
    .enable_i          (enable),
    .reset_count_i     (reset_count),
    .ref_clk_en_i      (ref_clk_en),
    .prescaler_en_i    (prescaler_en),
    .prescaler_value_i (prescaler_value),
    .tick_o            (tick),
    .ref_edge_o        (ref_edge),
    .prescaler_count_o (prescaler_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_tick got %b want 0", tick);
    end
    checks++;
    if (prescaler_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count got %0d want 0", prescaler_count);
    end
    checks++;
    if (ref_edge !== 1'b0) begin
      errors++;
      $display("FAIL reset_ref_edge got %b want 0", ref_edge);
    end
    rst = 1'b0;
  endtask

  task automatic test_async_reset();
    prescaler_value = 8'd10;
    prescaler_en = 1'b1;
    ref_clk_en = 1'b0;
    enable = 1'b1;
    reset_count = 1'b1;
    step();
    reset_count = 1'b0;
    repeat (5) step();
    checks++;
    if (prescaler_count !== 8'd5) begin
      errors++;
      $display("FAIL pre_rst_count got %0d want 5", prescaler_count);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (prescaler_count !== 8'd0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got cnt=%0d tick=%b want 0 0",
               prescaler_count, tick);
    end
    prescaler_en = 1'b0;
    #2;
    rst = 1'b0;
    step();
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_tick got %b want 1", tick);
    end
  endtask

  task automatic test_clk_div();
    enable = 1'b0;
    reset_count = 1'b1;
    step();
    reset_count = 1'b0;
    prescaler_en = 1'b1;
    prescaler_value = 8'd3;
    enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++;
      if (tick !== ((i % 4) == 0)) begin
        errors++;
        $display("FAIL div3_tick cyc %0d got %b want %b",
                 i, tick, (i % 4) == 0);
      end
      checks++;
      if (prescaler_count !== 8'(i % 4)) begin
        errors++;
        $display("FAIL div3_count cyc %0d got %0d want %0d",
                 i, prescaler_count, i % 4);
      end
    end
  endtask

  task automatic test_ref();
    int nticks;
    int bad;
    nticks = 0;
    bad = 0;
    prescaler_en = 1'b0;
    ref_clk_en = 1'b1;
    ref_clk = 1'b0;
    repeat (4) step();
    for (int c = 0; c < 50; c++) begin
      ref_clk = (c % 10) < 5;
      step();
      if (tick === 1'b1) nticks++;
      checks++;
      if (ref_edge !== ((c % 10) == 1)) begin
        errors++;
        bad++;
        $display("FAIL ref_edge c %0d got %b want %b",
                 c, ref_edge, (c % 10) == 1);
      end
      checks++;
      if (tick !== ((c % 10) == 2)) begin
        errors++;
        bad++;
        $display("FAIL ref_tick c %0d got %b want %b",
                 c, tick, (c % 10) == 2);
      end
    end
    checks++;
    if (nticks != 5) begin
      errors++;
      $display("FAIL ref_tick_total got %0d want 5", nticks);
    end
    ref_clk = 1'b0;
    ref_clk_en = 1'b0;
  endtask

  task automatic test_value_change();
    prescaler_en = 1'b1;
    prescaler_value = 8'd10;
    reset_count = 1'b1;
    step();
    reset_count = 1'b0;
    repeat (7) step();
    checks++;
    if (prescaler_count !== 8'd7 || tick !== 1'b0) begin
      errors++;
      $display("FAIL vc_pre got cnt=%0d tick=%b want 7 0",
               prescaler_count, tick);
    end
    prescaler_value = 8'd4;
    step();
    checks++;
    if (prescaler_count !== 8'd0 || tick !== 1'b1) begin
      errors++;
      $display("FAIL vc_wrap got cnt=%0d tick=%b want 0 1",
               prescaler_count, tick);
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (tick !== (i == 5) || prescaler_count !== 8'(i % 5)) begin
        errors++;
        $display("FAIL vc_next %0d got cnt=%0d tick=%b want %0d %b",
                 i, prescaler_count, tick, i % 5, i == 5);
      end
    end
  endtask

  task automatic test_priority();
    prescaler_value = 8'd2;
    reset_count = 1'b1;
    step();
    reset_count = 1'b0;
    repeat (2) step();
    checks++;
    if (prescaler_count !== 8'd2) begin
      errors++;
      $display("FAIL pri_pre got %0d want 2", prescaler_count);
    end
    reset_count = 1'b1;
    step();
    reset_count = 1'b0;
    checks++;
    if (prescaler_count !== 8'd0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL pri_clear got cnt=%0d tick=%b want 0 0",
               prescaler_count, tick);
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (prescaler_count !== 8'd0 || tick !== 1'b0) begin
        errors++;
        $display("FAIL pri_dis0 %0d got cnt=%0d tick=%b want 0 0",
                 i, prescaler_count, tick);
      end
    end
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (prescaler_count !== 8'd1 || tick !== 1'b0) begin
        errors++;
        $display("FAIL pri_dis1 %0d got cnt=%0d tick=%b want 1 0",
                 i, prescaler_count, tick);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_value_zero();
    prescaler_value = 8'd0;
    prescaler_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) prescaler_en = 1'b0;
      step();
      checks++;
      if (tick !== 1'b1 || prescaler_count !== 8'd0) begin
        errors++;
        $display("FAIL val0 %0d got cnt=%0d tick=%b want 0 1",
                 i, prescaler_count, tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_clk_div();
    test_ref();
    test_value_change();
    test_priority();
    test_value_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
